// File: rtl/block_load_ctrl_if.sv
// SRAM read port and 8x8 buffer write port of the block loader.
// master = controller side, slave = SRAM/buffer side.
interface block_load_ctrl_if #(
    parameter int AW = 18,
    parameter int DW = 16
) ();
    logic [AW-1:0] sram_addr;
    logic          sram_rd_req;
    logic          sram_rd_valid;
    logic [DW-1:0] sram_rd_data;
    logic          buf_wen;
    logic [2:0]    buf_row;
    logic [2:0]    buf_col;
    logic [7:0]    buf_wdata;

    modport master (
        output sram_addr, sram_rd_req,
        output buf_wen, buf_row, buf_col, buf_wdata,
        input  sram_rd_valid, sram_rd_data
    );

    modport slave (
        input  sram_addr, sram_rd_req,
        input  buf_wen, buf_row, buf_col, buf_wdata,
        output sram_rd_valid, sram_rd_data
    );
endinterface

// File: rtl/block_load_ctrl.sv
// Loads one 8x8 block from SRAM into the requantized pixel buffer,
// then hands the buffer to part-2 until it is released.
module block_load_ctrl #(
    parameter int AW    = 18,
    parameter int DW    = 16,
    parameter int SHIFT = 8
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] line_stride,
    input  logic          part2_done,
    output logic          busy,
    output logic          done,
    output logic          start_part2,
    block_load_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_DONE,
        S_HOLD
    } state_t;

    localparam logic signed [DW-1:0] QMAX = 255;

    state_t        state_q, state_d;
    logic [2:0]    i_q, i_d;
    logic [2:0]    j_q, j_d;
    logic [AW-1:0] row_q, row_d;
    logic [AW-1:0] stride_q, stride_d;
    logic [7:0]    wdata_q, wdata_d;

    logic                 accept;
    logic                 last;
    logic signed [DW-1:0] shifted;
    logic [7:0]           q_val;

    assign accept = (state_q == S_IDLE) && start && !abort;
    assign last   = (i_q == 3'd7) && (j_q == 3'd7);

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every transition
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (bus.sram_rd_valid) state_d = S_WRITE;
            S_WRITE: state_d = last ? S_DONE : S_ISSUE;
            S_DONE:  state_d = S_HOLD;
            S_HOLD:  if (part2_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
    end

    // Outputs decoded from registered state and datapath
    always_comb begin
        bus.sram_rd_req = (state_q == S_ISSUE);
        bus.sram_addr   = row_q + {{(AW-3){1'b0}}, j_q};
        bus.buf_wen     = (state_q == S_WRITE);
        bus.buf_row     = i_q;
        bus.buf_col     = j_q;
        bus.buf_wdata   = wdata_q;
        busy            = (state_q != S_IDLE);
        done            = (state_q == S_DONE);
        start_part2     = (state_q == S_DONE);
    end

    // Requantize: arithmetic shift, then clamp to 0..255
    always_comb begin
        shifted = $signed(bus.sram_rd_data) >>> SHIFT;
        if (shifted < 0) begin
            q_val = 8'd0;
        end else if (shifted > QMAX) begin
            q_val = 8'hFF;
        end else begin
            q_val = shifted[7:0];
        end
    end

    // Datapath next state: row base advances by stride as i steps
    always_comb begin
        i_d      = i_q;
        j_d      = j_q;
        row_d    = row_q;
        stride_d = stride_q;
        wdata_d  = wdata_q;
        if (accept) begin
            i_d      = 3'd0;
            j_d      = 3'd0;
            row_d    = base_addr;
            stride_d = line_stride;
        end
        if ((state_q == S_WAIT) && bus.sram_rd_valid) begin
            wdata_d = q_val;
        end
        if (state_q == S_WRITE) begin
            j_d = j_q + 3'd1;
            if (j_q == 3'd7) begin
                i_d   = i_q + 3'd1;
                row_d = row_q + stride_q;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            i_q      <= '0;
            j_q      <= '0;
            row_q    <= '0;
            stride_q <= '0;
            wdata_q  <= '0;
        end else begin
            i_q      <= i_d;
            j_q      <= j_d;
            row_q    <= row_d;
            stride_q <= stride_d;
            wdata_q  <= wdata_d;
        end
    end

endmodule

// File: tb/tb_block_load_ctrl.sv
// Randomized bench for block_load_ctrl with a
// transaction-level reference model.
module tb_block_load_ctrl;

    localparam int AW = 18;
    localparam int DW = 16;
    localparam int SH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          part2_done;
    logic [AW-1:0] base;
    logic [AW-1:0] stride;
    logic          busy;
    logic          done;
    logic          sp2;

    always #5 clk = ~clk;

    block_load_ctrl_if #(.AW(AW), .DW(DW)) bus ();

    block_load_ctrl #(.AW(AW), .DW(DW), .SHIFT(SH)) dut (
        .clock       (clk),
        .reset_n     (rst_n),
        .start       (start),
        .abort       (abort),
        .base_addr   (base),
        .line_stride (stride),
        .part2_done  (part2_done),
        .busy        (busy),
        .done        (done),
        .start_part2 (sp2),
        .bus         (bus.master)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    logic [15:0] mem [logic [AW-1:0]];

    function automatic logic [15:0] mem_rd(input logic [AW-1:0] a);
        if (!mem.exists(a)) mem[a] = 16'($urandom);
        return mem[a];
    endfunction

    function automatic int ref_q(input logic [15:0] d);
        int v;
        v = int'($signed(d)) >>> SH;
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // responder config / state
    int            cnt = 0;
    logic [AW-1:0] pend;
    int            lat_min = 1;
    int            lat_max = 1;
    bit            spur = 0;
    bit            p2_in_done = 0;
    bit            p2_req = 0;

    // logs
    logic [AW-1:0] req_a[$];
    int req_c[$];
    int lat_q[$];
    int wr_r[$];
    int wr_c[$];
    int wr_d[$];
    int wr_t[$];
    int done_t[$];
    int sp2_t[$];
    int busy_rise = -1;
    logic busy_prev = 1'b0;

    // SRAM model: one response after a random number of WAIT cycles,
    // optional junk valids while the DUT is issuing or writing
    initial begin : responder
        int l;
        bus.sram_rd_valid = 1'b0;
        bus.sram_rd_data  = '0;
        part2_done        = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            bus.sram_rd_valid = 1'b0;
            bus.sram_rd_data  = 16'($urandom);
            if (!rst_n) cnt = 0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.sram_rd_valid = 1'b1;
                    bus.sram_rd_data  = mem_rd(pend);
                end
            end
            if (rst_n && bus.sram_rd_req) begin
                l = $urandom_range(lat_max, lat_min);
                pend = bus.sram_addr;
                cnt = l;
                lat_q.push_back(l);
            end
            if (spur && !bus.sram_rd_valid &&
                (bus.sram_rd_req || bus.buf_wen) &&
                $urandom_range(1, 0) == 1)
                bus.sram_rd_valid = 1'b1;
            part2_done = p2_req || (p2_in_done && done);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.sram_rd_req) begin
                req_a.push_back(bus.sram_addr);
                req_c.push_back(cyc);
            end
            if (bus.buf_wen) begin
                wr_r.push_back(int'(bus.buf_row));
                wr_c.push_back(int'(bus.buf_col));
                wr_d.push_back(int'(bus.buf_wdata));
                wr_t.push_back(cyc);
            end
            if (done) done_t.push_back(cyc);
            if (sp2) sp2_t.push_back(cyc);
            if (busy && !busy_prev) busy_rise <= cyc;
        end
        busy_prev <= busy;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        req_a.delete(); req_c.delete(); lat_q.delete();
        wr_r.delete(); wr_c.delete(); wr_d.delete(); wr_t.delete();
        done_t.delete(); sp2_t.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_addr"}, bus.sram_addr, 0);
        chk({tag, "_req"}, bus.sram_rd_req, 0);
        chk({tag, "_wen"}, bus.buf_wen, 0);
        chk({tag, "_row"}, bus.buf_row, 0);
        chk({tag, "_col"}, bus.buf_col, 0);
        chk({tag, "_wdata"}, bus.buf_wdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_sp2"}, sp2, 0);
    endtask

    task automatic start_block(input logic [AW-1:0] b,
                               input logic [AW-1:0] s, output int e);
        clear_logs();
        base  = b;
        stride = s;
        start = 1'b1;
        e = cyc;
        tick();
        start  = 1'b0;
        base   = AW'($urandom);
        stride = AW'($urandom);
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 3000 && done_t.size() == 0; k++) tick();
        chk({tag, "_done_seen"}, done_t.size() > 0, 1);
    endtask

    // expected element order, addresses, data and cycle timing
    task automatic check_block(input string tag, input logic [AW-1:0] b,
                               input logic [AW-1:0] s, input int e,
                               input int n, output int t);
        logic [AW-1:0] a, ai, aj;
        int L;
        chk({tag, "_nwr"}, wr_r.size(), n);
        chk({tag, "_nreq"}, req_a.size(), n);
        t = e + 1;
        for (int k = 0; k < n; k++) begin
            ai = AW'(k / 8);
            aj = AW'(k % 8);
            a = b + ai * s + aj;
            L = (k < lat_q.size()) ? lat_q[k] : 1;
            if (k < req_a.size()) begin
                chk($sformatf("%s_addr%0d", tag, k), req_a[k], a);
                chk($sformatf("%s_reqt%0d", tag, k), req_c[k], t);
            end
            if (k < wr_r.size()) begin
                chk($sformatf("%s_row%0d", tag, k), wr_r[k], k / 8);
                chk($sformatf("%s_col%0d", tag, k), wr_c[k], k % 8);
                chk($sformatf("%s_dat%0d", tag, k), wr_d[k],
                    ref_q(mem_rd(a)));
                chk($sformatf("%s_wrt%0d", tag, k), wr_t[k], t + L + 1);
            end
            t = t + L + 2;
        end
    endtask

    task automatic check_full(input string tag, input logic [AW-1:0] b,
                              input logic [AW-1:0] s, input int e);
        int t;
        wait_done(tag);
        check_block(tag, b, s, e, 64, t);
        chk({tag, "_ndone"}, done_t.size(), 1);
        chk({tag, "_nsp2"}, sp2_t.size(), 1);
        if (done_t.size() > 0) chk({tag, "_donet"}, done_t[0], t);
        if (sp2_t.size() > 0) chk({tag, "_sp2t"}, sp2_t[0], t);
        chk({tag, "_busyrise"}, busy_rise, e + 1);
    endtask

    task automatic release_buf(input string tag);
        p2_req = 1'b1;
        tick();
        p2_req = 1'b0;
        chk({tag, "_idle_after_p2"}, busy, 0);
    endtask

    initial begin : main
        int e, t, nreq;
        logic [AW-1:0] b, s;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        base = '0;
        stride = '0;
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();

        // start and abort together in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", busy, 0);
        tick();
        tick();
        chk("start_abort_nreq", req_a.size(), 0);

        // block A: k<<8 pattern, fixed latency, handoff behaviour
        for (int k = 0; k < 64; k++) mem[AW'(18'h100 + k)] = 16'(k << 8);
        p2_in_done = 1'b1;
        start_block(18'h100, 18'd8, e);
        check_full("blkA", 18'h100, 18'd8, e);
        p2_in_done = 1'b0;
        tick();
        tick();
        chk("hold_ignores_p2_in_done", busy, 1);
        nreq = req_a.size();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("hold_start_busy", busy, 1);
        chk("hold_start_nreq", req_a.size(), nreq);
        release_buf("blkA");

        // block B: clamp corner values, started in the release IDLE cycle
        lat_min = 1;
        lat_max = 5;
        spur = 1'b1;
        b = AW'($urandom);
        s = AW'($urandom_range(200, 8));
        mem[b]        = 16'h7FF0;
        mem[b + 18'd1] = 16'h0FF0;
        mem[b + 18'd2] = 16'h8000;
        mem[b + 18'd3] = 16'h0000;
        start_block(b, s, e);
        check_full("blkB", b, s, e);
        if (wr_d.size() >= 4) begin
            chk("clamp_7ff0", wr_d[0], 255);
            chk("clamp_0ff0", wr_d[1], 255);
            chk("clamp_8000", wr_d[2], 0);
            chk("clamp_0000", wr_d[3], 0);
        end
        release_buf("blkB");

        // block C: address wrap-around
        start_block(18'h3FFFC, 18'h40, e);
        check_full("blkC", 18'h3FFFC, 18'h40, e);
        if (req_a.size() > 8) begin
            chk("wrap_0_4", req_a[4], 18'h00000);
            chk("wrap_1_0", req_a[8], 18'h0003C);
        end
        release_buf("blkC");

        // random blocks
        for (int r = 0; r < 2; r++) begin
            b = AW'($urandom);
            s = AW'($urandom);
            start_block(b, s, e);
            check_full($sformatf("rnd%0d", r), b, s, e);
            release_buf($sformatf("rnd%0d", r));
        end

        // abort on the write of element 20
        b = AW'($urandom);
        s = AW'($urandom_range(64, 8));
        start_block(b, s, e);
        for (int k = 0; k < 2000 &&
             !(bus.buf_wen && bus.buf_row == 3'd2 && bus.buf_col == 3'd4);
             k++) tick();
        chk("abort_reach_el20", bus.buf_wen, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        for (int k = 0; k < 20; k++) tick();
        chk("abort_ndone", done_t.size(), 0);
        chk("abort_nsp2", sp2_t.size(), 0);
        check_block("abort", b, s, e, 21, t);

        // reset while waiting for read data
        spur = 1'b0;
        lat_min = 3;
        lat_max = 3;
        b = AW'($urandom);
        s = AW'($urandom);
        start_block(b, s, e);
        for (int k = 0; k < 2000 &&
             !(req_a.size() >= 6 && busy &&
               !bus.sram_rd_req && !bus.buf_wen);
             k++) tick();
        chk("rst_reach_wait", req_a.size(), 6);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("rst_wait");
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst_first_edge_idle", busy, 0);
        lat_min = 1;
        lat_max = 1;
        b = AW'($urandom);
        s = AW'($urandom);
        start_block(b, s, e);
        check_full("restart", b, s, e);
        release_buf("restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
